// File: rtl/jk_reg_bank.sv
// ---------------------------------------------------------------------------
// jk_reg_bank
//
// Purpose:
//   A bank of WIDTH independent flip-flop channels. The same state register
//   can act as per-bit JK flip-flops, a D register, T flip-flops or a binary
//   up-counter, chosen by 'mode'. A parallel load overrides every mode.
//   All outputs are registered and change only on the rising edge of clk.
//
// Parameters:
//   WIDTH      number of channels (1..32)
//   RESET_VAL  value q takes on reset
//
// Ports:
//   clk       in   single clock, rising-edge active
//   reset_n   in   synchronous active-low reset (highest priority)
//   en        in   update enable for JK/D/T/counter operation
//   mode      in   00 JK, 01 D, 10 T, 11 counter
//   j         in   per-channel J (D in D mode, T in T mode)
//   k         in   per-channel K (only used in JK mode)
//   load      in   parallel-load strobe (beats en)
//   load_val  in   value written on load
//   q         out  registered state
//   qbar      out  registered complement of q
//   tc        out  one-cycle pulse after a counter wrap from all-ones to zero
//   changed   out  high in the cycle after q took a new value (not on reset)
// ---------------------------------------------------------------------------
module jk_reg_bank #(
    parameter int              WIDTH     = 8,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             en,
    input  logic [1:0]       mode,
    input  logic [WIDTH-1:0] j,
    input  logic [WIDTH-1:0] k,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] qbar,
    output logic             tc,
    output logic             changed
);

    typedef enum logic [1:0] {
        MODE_JK  = 2'b00,
        MODE_D   = 2'b01,
        MODE_T   = 2'b10,
        MODE_CNT = 2'b11
    } mode_t;

    mode_t            cur_mode;
    logic [WIDTH-1:0] next_q;
    logic             wrap;

    assign cur_mode = mode_t'(mode);

    // Next-state selection. Load beats enable; with neither active the
    // register holds. The JK equation (j & ~q) | (~k & q) gives hold, clear,
    // set and toggle for {j,k} = 00, 01, 10, 11 on every bit at once.
    // A wrap is only flagged when the counter itself rolls over, so reaching
    // zero by load or by another mode never raises tc.
    always_comb begin
        next_q = q;
        wrap   = 1'b0;
        if (load) begin
            next_q = load_val;
        end else if (en) begin
            case (cur_mode)
                MODE_JK:  next_q = (j & ~q) | (~k & q);
                MODE_D:   next_q = j;
                MODE_T:   next_q = q ^ j;
                MODE_CNT: begin
                    next_q = q + WIDTH'(1);
                    wrap   = (q == '1);
                end
                default:  next_q = q;
            endcase
        end
    end

    // State and output registers. qbar is stored alongside q rather than
    // derived from it so both settle on the same edge, including reset.
    // Reset is sampled synchronously and clears the status flags even if
    // the reset itself moved q.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            q       <= RESET_VAL;
            qbar    <= ~RESET_VAL;
            tc      <= 1'b0;
            changed <= 1'b0;
        end else begin
            q       <= next_q;
            qbar    <= ~next_q;
            tc      <= wrap;
            changed <= (next_q != q);
        end
    end

endmodule

// File: tb/tb_jk_reg_bank.sv
// ---------------------------------------------------------------------------
// tb_jk_reg_bank
//
// Purpose:
//   Directed self-checking bench for jk_reg_bank. Two instances share the
//   control inputs: an 8-bit bank with a non-zero reset value and a 4-bit
//   bank used for counter wrap behaviour. Inputs change 1 ns after a rising
//   edge and outputs are sampled at that same point, away from the edge.
// ---------------------------------------------------------------------------
module tb_jk_reg_bank;

    logic       clk;
    logic       reset_n;
    logic       en;
    logic [1:0] mode;
    logic       load;

    logic [7:0] j8, k8, lv8, q8, qbar8;
    logic       tc8, changed8;

    logic [3:0] j4, k4, lv4, q4, qbar4;
    logic       tc4, changed4;

    int errors;
    int checks;

    jk_reg_bank #(.WIDTH(8), .RESET_VAL(8'h5A)) dut8 (
        .clk      (clk),
        .reset_n  (reset_n),
        .en       (en),
        .mode     (mode),
        .j        (j8),
        .k        (k8),
        .load     (load),
        .load_val (lv8),
        .q        (q8),
        .qbar     (qbar8),
        .tc       (tc8),
        .changed  (changed8)
    );

    jk_reg_bank #(.WIDTH(4)) dut4 (
        .clk      (clk),
        .reset_n  (reset_n),
        .en       (en),
        .mode     (mode),
        .j        (j4),
        .k        (k4),
        .load     (load),
        .load_val (lv4),
        .q        (q4),
        .qbar     (qbar4),
        .tc       (tc4),
        .changed  (changed4)
    );

    // 10 ns clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Advance one rising edge and settle 1 ns past it
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reset wins over load and en; the following edge then loads normally.
    // A reset pulse that starts and ends between edges must be ignored.
    task automatic test_reset();
        reset_n = 1'b0; load = 1'b1; lv8 = 8'hAA; lv4 = 4'h9; en = 1'b1; mode = 2'b11;
        step();
        checks++; if (q8 !== 8'h5A) begin errors++; $display("[TB] FAIL reset_q8: got %h expected %h", q8, 8'h5A); end
        checks++; if (qbar8 !== 8'hA5) begin errors++; $display("[TB] FAIL reset_qbar8: got %h expected %h", qbar8, 8'hA5); end
        checks++; if (tc8 !== 1'b0) begin errors++; $display("[TB] FAIL reset_tc8: got %b expected 0", tc8); end
        checks++; if (changed8 !== 1'b0) begin errors++; $display("[TB] FAIL reset_changed8: got %b expected 0", changed8); end
        checks++; if (q4 !== 4'h0) begin errors++; $display("[TB] FAIL reset_q4: got %h expected %h", q4, 4'h0); end
        checks++; if (qbar4 !== 4'hF) begin errors++; $display("[TB] FAIL reset_qbar4: got %h expected %h", qbar4, 4'hF); end

        reset_n = 1'b1;
        step();
        checks++; if (q8 !== 8'hAA) begin errors++; $display("[TB] FAIL priority_load_q8: got %h expected %h", q8, 8'hAA); end
        checks++; if (changed8 !== 1'b1) begin errors++; $display("[TB] FAIL priority_load_changed8: got %b expected 1", changed8); end
        checks++; if (q4 !== 4'h9) begin errors++; $display("[TB] FAIL priority_load_q4: got %h expected %h", q4, 4'h9); end

        load = 1'b0; en = 1'b0;
        #2 reset_n = 1'b0;
        #2 reset_n = 1'b1;
        step();
        checks++; if (q8 !== 8'hAA) begin errors++; $display("[TB] FAIL glitch_reset_q8: got %h expected %h", q8, 8'hAA); end
    endtask

    // JK truth table across all four {j,k} pairs in one vector
    task automatic test_jk();
        load = 1'b1; lv8 = 8'h0F;
        step();
        load = 1'b0; en = 1'b1; mode = 2'b00; j8 = 8'hF0; k8 = 8'h3C;
        step();
        checks++; if (q8 !== 8'hF3) begin errors++; $display("[TB] FAIL jk_q: got %h expected %h", q8, 8'hF3); end
        checks++; if (qbar8 !== 8'h0C) begin errors++; $display("[TB] FAIL jk_qbar: got %h expected %h", qbar8, 8'h0C); end
        checks++; if (changed8 !== 1'b1) begin errors++; $display("[TB] FAIL jk_changed: got %b expected 1", changed8); end
        checks++; if (tc8 !== 1'b0) begin errors++; $display("[TB] FAIL jk_tc: got %b expected 0", tc8); end
    endtask

    // With en and load low, every mode holds for five edges
    task automatic test_hold();
        en = 1'b0; load = 1'b0; j8 = 8'hFF; k8 = 8'hFF;
        for (int m = 0; m < 4; m++) begin
            mode = 2'(m);
            for (int e = 0; e < 5; e++) begin
                step();
                checks++; if (q8 !== 8'hF3) begin errors++; $display("[TB] FAIL hold_q mode=%0d edge=%0d: got %h expected %h", m, e, q8, 8'hF3); end
                checks++; if (changed8 !== 1'b0) begin errors++; $display("[TB] FAIL hold_changed mode=%0d edge=%0d: got %b expected 0", m, e, changed8); end
            end
        end
    endtask

    // T toggles selected bits, D copies j; repeating the same D value is not a change
    task automatic test_t_d();
        load = 1'b1; lv8 = 8'h55;
        step();
        load = 1'b0; en = 1'b1; mode = 2'b10; j8 = 8'hFF;
        step();
        checks++; if (q8 !== 8'hAA) begin errors++; $display("[TB] FAIL t_q: got %h expected %h", q8, 8'hAA); end
        checks++; if (qbar8 !== 8'h55) begin errors++; $display("[TB] FAIL t_qbar: got %h expected %h", qbar8, 8'h55); end
        mode = 2'b01; j8 = 8'h3C;
        step();
        checks++; if (q8 !== 8'h3C) begin errors++; $display("[TB] FAIL d_q: got %h expected %h", q8, 8'h3C); end
        checks++; if (changed8 !== 1'b1) begin errors++; $display("[TB] FAIL d_changed: got %b expected 1", changed8); end
        step();
        checks++; if (changed8 !== 1'b0) begin errors++; $display("[TB] FAIL d_same_changed: got %b expected 0", changed8); end
        mode = 2'b10; j8 = 8'h81;
        step();
        checks++; if (q8 !== 8'hBD) begin errors++; $display("[TB] FAIL t_partial_q: got %h expected %h", q8, 8'hBD); end
    endtask

    // 4-bit counter: E -> F -> 0 (tc) -> 1
    task automatic test_counter_wrap();
        load = 1'b1; lv4 = 4'hE; en = 1'b0;
        step();
        checks++; if (q4 !== 4'hE) begin errors++; $display("[TB] FAIL cnt_load_q: got %h expected %h", q4, 4'hE); end
        load = 1'b0; mode = 2'b11; en = 1'b1;
        step();
        checks++; if (q4 !== 4'hF) begin errors++; $display("[TB] FAIL cnt_q_f: got %h expected %h", q4, 4'hF); end
        checks++; if (tc4 !== 1'b0) begin errors++; $display("[TB] FAIL cnt_tc_f: got %b expected 0", tc4); end
        step();
        checks++; if (q4 !== 4'h0) begin errors++; $display("[TB] FAIL cnt_q_0: got %h expected %h", q4, 4'h0); end
        checks++; if (tc4 !== 1'b1) begin errors++; $display("[TB] FAIL cnt_tc_0: got %b expected 1", tc4); end
        step();
        checks++; if (q4 !== 4'h1) begin errors++; $display("[TB] FAIL cnt_q_1: got %h expected %h", q4, 4'h1); end
        checks++; if (tc4 !== 1'b0) begin errors++; $display("[TB] FAIL cnt_tc_1: got %b expected 0", tc4); end
        step();
        checks++; if (q4 !== 4'h2) begin errors++; $display("[TB] FAIL cnt_q_2: got %h expected %h", q4, 4'h2); end
    endtask

    // Reaching zero through load or D mode must not raise tc
    task automatic test_load_zero();
        load = 1'b1; lv4 = 4'hF; mode = 2'b11; en = 1'b1;
        step();
        checks++; if (q4 !== 4'hF) begin errors++; $display("[TB] FAIL lz_setup_q: got %h expected %h", q4, 4'hF); end
        lv4 = 4'h0;
        step();
        checks++; if (q4 !== 4'h0) begin errors++; $display("[TB] FAIL lz_q: got %h expected %h", q4, 4'h0); end
        checks++; if (tc4 !== 1'b0) begin errors++; $display("[TB] FAIL lz_tc: got %b expected 0", tc4); end
        checks++; if (changed4 !== 1'b1) begin errors++; $display("[TB] FAIL lz_changed: got %b expected 1", changed4); end
        lv4 = 4'hF;
        step();
        load = 1'b0; mode = 2'b01; j4 = 4'h0;
        step();
        checks++; if (q4 !== 4'h0) begin errors++; $display("[TB] FAIL dz_q: got %h expected %h", q4, 4'h0); end
        checks++; if (tc4 !== 1'b0) begin errors++; $display("[TB] FAIL dz_tc: got %b expected 0", tc4); end
    endtask

    // Reset mid-count clears state and flags; counting resumes from reset value
    task automatic test_reset_midcount();
        mode = 2'b11; en = 1'b1; load = 1'b0;
        step();
        step();
        checks++; if (q4 !== 4'h2) begin errors++; $display("[TB] FAIL mid_pre_q: got %h expected %h", q4, 4'h2); end
        reset_n = 1'b0;
        step();
        checks++; if (q4 !== 4'h0) begin errors++; $display("[TB] FAIL mid_reset_q: got %h expected %h", q4, 4'h0); end
        checks++; if (changed4 !== 1'b0) begin errors++; $display("[TB] FAIL mid_reset_changed: got %b expected 0", changed4); end
        checks++; if (q8 !== 8'h5A) begin errors++; $display("[TB] FAIL mid_reset_q8: got %h expected %h", q8, 8'h5A); end
        reset_n = 1'b1;
        step();
        checks++; if (q4 !== 4'h1) begin errors++; $display("[TB] FAIL mid_resume_q: got %h expected %h", q4, 4'h1); end
        checks++; if (q8 !== 8'h5B) begin errors++; $display("[TB] FAIL mid_resume_q8: got %h expected %h", q8, 8'h5B); end
    endtask

    initial begin
        errors  = 0;
        checks  = 0;
        reset_n = 1'b0;
        en      = 1'b0;
        mode    = 2'b00;
        load    = 1'b0;
        j8 = '0; k8 = '0; lv8 = '0;
        j4 = '0; k4 = '0; lv4 = '0;
        #1;
        $display("[TB] starting jk_reg_bank bench");
        test_reset();
        test_jk();
        test_hold();
        test_t_d();
        test_counter_wrap();
        test_load_zero();
        test_reset_midcount();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/jk_reg_bank.md
JK_REG_BANK -- requirements
Module: jk_reg_bank

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8, giving the number of independent flip-flop channels (legal range 1..32).
REQ-002 The block SHALL have parameter RESET_VAL, default 0 (WIDTH bits), giving the value q takes on reset.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state changes occur on its rising edge.
REQ-004 The block SHALL have port reset_n, input, 1 bit: synchronous, active-low reset.
REQ-005 The block SHALL have port en, input, 1 bit: update enable for JK/D/T/counter operation.
REQ-006 The block SHALL have port mode, input, 2 bits: 00 JK, 01 D, 10 T, 11 counter.
REQ-007 The block SHALL have port j, input, WIDTH bits: per-channel J (D in D mode, T in T mode).
REQ-008 The block SHALL have port k, input, WIDTH bits: per-channel K (ignored outside JK mode).
REQ-009 The block SHALL have port load, input, 1 bit: parallel-load strobe.
REQ-010 The block SHALL have port load_val, input, WIDTH bits: value written on load.
REQ-011 The block SHALL have port q, output, WIDTH bits: registered state.
REQ-012 The block SHALL have port qbar, output, WIDTH bits: registered complement of q.
REQ-013 The block SHALL have port tc, output, 1 bit: registered terminal-count/wrap pulse.
REQ-014 The block SHALL have port changed, output, 1 bit: registered flag, high when q differs from its previous-cycle value.

Function
REQ-015 Per-edge priority SHALL be: reset_n low, then load, then en; with none active, q holds.
REQ-016 load SHALL write q <= load_val regardless of en or mode.
REQ-017 JK mode with en high SHALL apply, per bit i: {j,k}=00 hold, 01 clear, 10 set, 11 toggle.
REQ-018 D mode with en high SHALL set q <= j.
REQ-019 T mode with en high SHALL toggle each bit i where j[i]=1 and hold the others.
REQ-020 Counter mode with en high SHALL set q <= (q + 1) mod 2^WIDTH; each bit i toggles exactly when all lower bits are 1, which is JK toggle semantics, and j/k are ignored.
REQ-021 tc SHALL be 1 for exactly the one cycle in which q has just wrapped from all-ones to zero in counter mode, and 0 otherwise.
REQ-022 tc SHALL be 0 when q reaches zero via load, reset or a non-counter mode.
REQ-023 qbar SHALL equal ~q on every cycle, including the reset cycle; it is a registered output, not derived combinationally from a later q.
REQ-024 changed SHALL be registered: high in the cycle after any edge where the new q differs from the old q, from any cause except reset.
REQ-025 A mode change SHALL take effect on the same edge it is sampled; there is no pipeline, so update latency is 1 cycle for all modes.
REQ-026 Outputs SHALL settle only on clk rising edges, with no combinational path from inputs to outputs.

Reset
REQ-027 On a rising clk edge with reset_n=0, the block SHALL set q=RESET_VAL, qbar=~RESET_VAL, tc=0 and changed=0, overriding load and en.
REQ-028 Reset SHALL be honoured mid-operation, including mid-count and during load; the next edge with reset_n=1 resumes normal operation from RESET_VAL.
REQ-029 Changes of reset_n between clk edges SHALL have no effect on state.

Verification
REQ-030 The bench SHALL cover JK truth table with WIDTH=8, q=8'h0F, j=8'hF0, k=8'h3C, en=1, mode=00 -> q=8'hF3, qbar=8'h0C, changed=1.
REQ-031 The bench SHALL cover counter wrap with WIDTH=4, load 4'hE, then mode=11, en=1 for 3 edges -> q=F, 0, 1; tc=1 only in the cycle q=0.
REQ-032 The bench SHALL cover priority with reset_n=0, load=1, load_val=8'hAA, en=1 -> q=RESET_VAL, tc=0, changed=0; next edge with reset_n=1, load=1 -> q=8'hAA.
REQ-033 The bench SHALL cover hold with en=0, load=0 for 5 edges, every mode -> q unchanged and changed=0.
REQ-034 The bench SHALL cover T/D modes with q=8'h55: mode=10, j=8'hFF -> q=8'hAA; then mode=01, j=8'h3C -> q=8'h3C.
REQ-035 The bench SHALL cover load of zero while q=all-ones in counter mode -> q=0, tc=0.
